// File: rtl/qcm_seq_pkg.sv
// Shared types and constants for the capacitor-state sweep sequencer.
package qcm_seq_pkg;

  localparam int unsigned DefStateW = 7;
  localparam int unsigned DefDwellW = 16;
  localparam int unsigned DefTmoW   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StWaitEn,
    StHoldEn,
    StDwell,
    StDone
  } seq_state_e;

  // Enable-wait timeout in cycles for a given counter width.
  function automatic int unsigned tmo_limit(input int unsigned tmo_w);
    return (1 << tmo_w) - 1;
  endfunction

  localparam int unsigned DefTmoLimit = tmo_limit(DefTmoW);

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter with zero flag; used for both dwell and enable-wait timeout.
module dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/state_sequencer.sv
// Sweep controller stepping the driver state from start to stop and waiting for each fire cycle.
// Define SEQ_PINGPONG_EN to sweep back to the start point after reaching the stop point.
module state_sequencer
  import qcm_seq_pkg::*;
#(
  parameter int unsigned STATE_W = DefStateW,
  parameter int unsigned DWELL_W = DefDwellW,
  parameter int unsigned TMO_W   = DefTmoW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [STATE_W-1:0] start_state_i,
  input  logic [STATE_W-1:0] stop_state_i,
  input  logic [STATE_W-1:0] step_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               drv_enable_i,
  output logic [STATE_W-1:0] drv_state_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               tmo_err_o,
  output logic [STATE_W:0]   point_cnt_o
);

  // Loaded in APPLY and counted down in WAIT_EN; zero marks the last allowed cycle.
  localparam logic [TMO_W-1:0] TmoLoad = TMO_W'(tmo_limit(TMO_W) - 1);

  seq_state_e         state_q, state_d;
  logic [STATE_W-1:0] cur_q, cur_d, stop_q, stop_d, step_q, step_d;
  logic [STATE_W-1:0] drv_state_q, drv_state_d, target;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [STATE_W:0]   point_cnt_q, point_cnt_d;
  logic               up_q, up_d, tmo_err_q, tmo_err_d, go_up;
  logic               dwell_load, dwell_dec, dwell_zero, tmo_load, tmo_dec, tmo_zero;
`ifdef SEQ_PINGPONG_EN
  logic [STATE_W-1:0] start_q, start_d;
  logic               leg_q, leg_d;
  assign target = leg_q ? start_q : stop_q;
  assign go_up  = up_q ^ leg_q;
`else
  assign target = stop_q;
  assign go_up  = up_q;
`endif

  // Next point toward tgt, computed one bit wider so wrap shows up as overshoot.
  function automatic logic [STATE_W-1:0] step_toward(input logic [STATE_W-1:0] cur,
                                                     input logic [STATE_W-1:0] stp,
                                                     input logic [STATE_W-1:0] tgt,
                                                     input logic up);
    logic [STATE_W:0] nxt;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      if (nxt > {1'b0, tgt}) nxt = {1'b0, tgt};
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      if (nxt[STATE_W] || (nxt < {1'b0, tgt})) nxt = {1'b0, tgt};
    end
    return nxt[STATE_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    up_d        = up_q;
    drv_state_d = drv_state_q;
    point_cnt_d = point_cnt_q;
    tmo_err_d   = tmo_err_q;
`ifdef SEQ_PINGPONG_EN
    start_d     = start_q;
    leg_d       = leg_q;
`endif
    dwell_load  = 1'b0;
    dwell_dec   = 1'b0;
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;
    if (abort_i && (state_q != StIdle) && (state_q != StDone)) begin
      state_d = StDone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            cur_d       = start_state_i;
            stop_d      = stop_state_i;
            step_d      = (step_i == '0) ? STATE_W'(1) : step_i;
            dwell_d     = dwell_i;
            up_d        = (stop_state_i >= start_state_i);
            point_cnt_d = '0;
            tmo_err_d   = 1'b0;
`ifdef SEQ_PINGPONG_EN
            start_d     = start_state_i;
            leg_d       = 1'b0;
`endif
            state_d     = StApply;
          end
        end
        StApply: begin
          drv_state_d = cur_q;
          tmo_load    = 1'b1;
          // An unchanged state never refires the driver, so skip the enable handshake.
          if (cur_q == drv_state_q) begin
            dwell_load = 1'b1;
            state_d    = StDwell;
          end else begin
            state_d = StWaitEn;
          end
        end
        StWaitEn: begin
          tmo_dec = 1'b1;
          if (drv_enable_i) begin
            state_d = StHoldEn;
          end else if (tmo_zero) begin
            tmo_err_d = 1'b1;
            state_d   = StDone;
          end
        end
        StHoldEn: begin
          if (!drv_enable_i) begin
            dwell_load = 1'b1;
            state_d    = StDwell;
          end
        end
        StDwell: begin
          if (dwell_zero) begin
            point_cnt_d = point_cnt_q + (STATE_W+1)'(1);
            if (cur_q == target) begin
              state_d = StDone;
`ifdef SEQ_PINGPONG_EN
              if (!leg_q && (start_q != stop_q)) begin
                leg_d   = 1'b1;
                cur_d   = step_toward(cur_q, step_q, start_q, !up_q);
                state_d = StApply;
              end
`endif
            end else begin
              cur_d   = step_toward(cur_q, step_q, target, go_up);
              state_d = StApply;
            end
          end else begin
            dwell_dec = 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      up_q        <= 1'b0;
      drv_state_q <= '0;
      point_cnt_q <= '0;
      tmo_err_q   <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      start_q     <= '0;
      leg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      up_q        <= up_d;
      drv_state_q <= drv_state_d;
      point_cnt_q <= point_cnt_d;
      tmo_err_q   <= tmo_err_d;
`ifdef SEQ_PINGPONG_EN
      start_q     <= start_d;
      leg_q       <= leg_d;
`endif
    end
  end

  dwell_timer #(
    .W(DWELL_W)
  ) u_dwell_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (dwell_load),
    .load_val_i (dwell_q),
    .dec_i      (dwell_dec),
    .zero_o     (dwell_zero)
  );

  dwell_timer #(
    .W(TMO_W)
  ) u_tmo_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmo_load),
    .load_val_i (TmoLoad),
    .dec_i      (tmo_dec),
    .zero_o     (tmo_zero)
  );

  assign drv_state_o = drv_state_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign tmo_err_o   = tmo_err_q;
  assign point_cnt_o = point_cnt_q;

endmodule
